// File: rtl/uart_tx_arbiter_if.sv
// uart_tx_arbiter_if
// Bundles every handshake between the message producers, the arbiter and
// the shared uart_tx transmitter.
//   req_lock/req_start/req_data : producer lock, byte request and byte lanes
//   grant/req_busy/owner_id     : ownership and busy returned to producers
//   timeout_pulse               : watchdog revoked the current grant
//   uart_tx_busy/start/data     : forwarded byte handshake to uart_tx
// Modports: slave = arbiter side, master = producers plus uart_tx side.
interface uart_tx_arbiter_if #(
  parameter int NUM_REQ = 3
);
  logic [NUM_REQ-1:0]   req_lock;
  logic [NUM_REQ-1:0]   req_start;
  logic [8*NUM_REQ-1:0] req_data;
  logic [NUM_REQ-1:0]   grant;
  logic [NUM_REQ-1:0]   req_busy;
  logic [2:0]           owner_id;
  logic                 timeout_pulse;
  logic                 uart_tx_busy;
  logic                 uart_tx_start;
  logic [7:0]           uart_tx_data;

  modport slave (
    input  req_lock, req_start, req_data, uart_tx_busy,
    output grant, req_busy, owner_id, timeout_pulse, uart_tx_start, uart_tx_data
  );

  modport master (
    output req_lock, req_start, req_data, uart_tx_busy,
    input  grant, req_busy, owner_id, timeout_pulse, uart_tx_start, uart_tx_data
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
// Shares one uart_tx between NUM_REQ producers. A producer raises req_lock
// for a whole message; ownership is granted round-robin and the owner's
// start/busy byte handshake is forwarded to uart_tx. A watchdog revokes
// the grant from an owner that holds the lock without starting a byte.
// Ports:
//   clk   : system clock
//   rst_n : asynchronous active-low reset
//   bus   : uart_tx_arbiter_if.slave (producer and uart_tx handshakes)
// Parameters: NUM_REQ (2..8), TIMEOUT_CYC idle limit, TO_WIDTH watchdog width.
module uart_tx_arbiter #(
  parameter int NUM_REQ     = 3,
  parameter int TIMEOUT_CYC = 100000,
  parameter int TO_WIDTH    = 17
) (
  input  logic              clk,
  input  logic              rst_n,
  uart_tx_arbiter_if.slave  bus
);

  typedef enum logic [2:0] {
    A_IDLE,
    A_GRANT,
    A_TX_WAIT_BUSY,
    A_TX_WAIT_DONE,
    A_BYTE_END,
    A_RELEASE
  } arb_state_t;

  localparam logic [NUM_REQ-1:0]  ONE_HOT0 = NUM_REQ'(1);
  localparam logic [TO_WIDTH-1:0] TO_LIMIT = TO_WIDTH'(TIMEOUT_CYC - 1);

  arb_state_t          state_q, state_next;
  logic [NUM_REQ-1:0]  grant_q, grant_next;
  logic [NUM_REQ-1:0]  busy_q, busy_next;
  logic [2:0]          owner_q, owner_next;
  logic                start_q, start_next;
  logic [7:0]          data_q, data_next;
  logic                pulse_q, pulse_next;
  logic [TO_WIDTH-1:0] wdog_q, wdog_next;

  logic                  owner_lock;
  logic                  owner_start;
  logic [7:0]            owner_data;
  logic [2*NUM_REQ-1:0]  lock_rot;
  logic                  win_found;
  int                    win_pos;

  // Next-state and next-output logic. The owner's signals are picked out
  // with the one-hot grant so non-owners can never influence the transmitter.
  // The round-robin scan rotates a doubled copy of req_lock so that bit 0 of
  // the rotated vector corresponds to owner_id+1; the lowest set bit wins.
  always_comb begin
    state_next = state_q;
    grant_next = grant_q;
    busy_next  = busy_q;
    owner_next = owner_q;
    start_next = start_q;
    data_next  = data_q;
    pulse_next = 1'b0;
    wdog_next  = wdog_q;

    owner_lock  = |(bus.req_lock & grant_q);
    owner_start = |(bus.req_start & grant_q);
    owner_data  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      owner_data = owner_data | (bus.req_data[8*i +: 8] & {8{grant_q[i]}});
    end

    lock_rot  = {bus.req_lock, bus.req_lock} >> (32'(owner_q) + 1);
    win_found = 1'b0;
    win_pos   = 0;
    for (int j = NUM_REQ - 1; j >= 0; j--) begin
      if (lock_rot[j]) begin
        win_found = 1'b1;
        win_pos   = (32'(owner_q) + 1 + j) % NUM_REQ;
      end
    end

    case (state_q)
      A_IDLE: begin
        if (win_found) begin
          grant_next = ONE_HOT0 << win_pos;
          owner_next = 3'(win_pos);
          wdog_next  = '0;
          state_next = A_GRANT;
        end
      end
      A_GRANT: begin
        if (!owner_lock) begin
          state_next = A_RELEASE;
        end else if (owner_start) begin
          data_next  = owner_data;
          start_next = 1'b1;
          state_next = A_TX_WAIT_BUSY;
        end else if (wdog_q == TO_LIMIT) begin
          pulse_next = 1'b1;
          state_next = A_RELEASE;
        end else begin
          wdog_next = wdog_q + TO_WIDTH'(1);
        end
      end
      A_TX_WAIT_BUSY: begin
        if (bus.uart_tx_busy) begin
          busy_next  = grant_q;
          state_next = A_TX_WAIT_DONE;
        end
      end
      A_TX_WAIT_DONE: begin
        if (!bus.uart_tx_busy) begin
          start_next = 1'b0;
          busy_next  = '0;
          state_next = A_BYTE_END;
        end
      end
      A_BYTE_END: begin
        // The lock is deliberately not checked here: a dropped lock is
        // handled in A_GRANT once the owner has released req_start.
        if (!owner_start) begin
          wdog_next  = '0;
          state_next = A_GRANT;
        end
      end
      A_RELEASE: begin
        grant_next = '0;
        state_next = A_IDLE;
      end
      default: begin
        state_next = A_IDLE;
      end
    endcase
  end

  // State and output registers. owner_id resets to the last index so the
  // first round-robin scan starts at requester 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= A_IDLE;
      grant_q <= '0;
      busy_q  <= '0;
      owner_q <= 3'(NUM_REQ - 1);
      start_q <= 1'b0;
      data_q  <= 8'h00;
      pulse_q <= 1'b0;
      wdog_q  <= '0;
    end else begin
      state_q <= state_next;
      grant_q <= grant_next;
      busy_q  <= busy_next;
      owner_q <= owner_next;
      start_q <= start_next;
      data_q  <= data_next;
      pulse_q <= pulse_next;
      wdog_q  <= wdog_next;
    end
  end

  assign bus.grant         = grant_q;
  assign bus.req_busy      = busy_q;
  assign bus.owner_id      = owner_q;
  assign bus.timeout_pulse = pulse_q;
  assign bus.uart_tx_start = start_q;
  assign bus.uart_tx_data  = data_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter
// Directed bench for uart_tx_arbiter with three requesters and a short
// watchdog. uart_tx is modelled as a 10-cycle busy window per byte.
module tb_uart_tx_arbiter;

  logic clk;
  logic rst_n;

  uart_tx_arbiter_if #(.NUM_REQ(3)) bus ();

  uart_tx_arbiter #(
    .NUM_REQ    (3),
    .TIMEOUT_CYC(16),
    .TO_WIDTH   (5)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int checkCount = 0;
  int passCount  = 0;

  logic [2:0]  lockV;
  logic [2:0]  startV;
  logic [23:0] dataV;

  logic [7:0] byteLog[$];
  int         busyCnt;
  logic       armed;
  int         busyCycles = 0;
  int         ffCycles   = 0;

  int         logBase;
  int         busyBase;
  int         ffBase;
  logic [1:0] rrIdx;

  // Free-running clock, 10 time units per cycle.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // uart_tx model: a start seen while idle (and after start has been low
  // since the previous byte) opens a 10-cycle busy window and logs the byte.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.uart_tx_busy <= 1'b0;
      busyCnt          <= 0;
      armed            <= 1'b1;
    end else begin
      if (!bus.uart_tx_start) armed <= 1'b1;
      if (bus.uart_tx_busy) begin
        if (busyCnt == 1) bus.uart_tx_busy <= 1'b0;
        busyCnt <= busyCnt - 1;
      end else if (bus.uart_tx_start && armed) begin
        bus.uart_tx_busy <= 1'b1;
        busyCnt          <= 10;
        armed            <= 1'b0;
        byteLog.push_back(bus.uart_tx_data);
      end
    end
  end

  // Mid-cycle monitors: busy cycles seen by requester 0 and any 0xFF byte.
  always @(negedge clk) begin
    if (bus.req_busy[0]) busyCycles++;
    if (bus.uart_tx_data == 8'hFF) ffCycles++;
  end

  // Hard stop in case something escapes the bounded waits.
  initial begin
    #2000000;
    $display("[TB] FAIL global_timeout: got no finish, expected finish");
    $fatal(1, "[TB] global timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [2:0] lock, input logic [2:0] start,
                               input logic [23:0] data);
    bus.req_lock  = lock;
    bus.req_start = start;
    bus.req_data  = data;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] got,
                             input logic [31:0] exp);
    checkCount++;
    if (got === exp) passCount++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  task automatic waitBusy(input logic [1:0] idx, input logic level, input string tag);
    int n = 0;
    while (bus.req_busy[idx] !== level && n < 400) begin
      tick();
      n++;
    end
    checkOutput(tag, 32'(bus.req_busy[idx]), 32'(level));
  endtask

  task automatic waitGrant(input logic [2:0] exp, input string tag);
    int n = 0;
    while (bus.grant !== exp && n < 400) begin
      tick();
      n++;
    end
    checkOutput(tag, 32'(bus.grant), 32'(exp));
  endtask

  task automatic waitGrantAny(input string tag);
    int n = 0;
    while (bus.grant === 3'b000 && n < 400) begin
      tick();
      n++;
    end
    checkOutput(tag, 32'(bus.grant != 3'b000), 1);
  endtask

  // One byte from requester idx: raise start, follow busy up and down,
  // drop start and give the arbiter one edge to return to A_GRANT.
  task automatic sendByte(input logic [1:0] idx, input logic [7:0] b);
    startV[idx] = 1'b1;
    dataV[{idx, 3'b000} +: 8] = b;
    applyStimulus(lockV, startV, dataV);
    waitBusy(idx, 1'b1, "busy_rise");
    waitBusy(idx, 1'b0, "busy_fall");
    startV[idx] = 1'b0;
    applyStimulus(lockV, startV, dataV);
    tick();
  endtask

  initial begin
    lockV  = 3'b000;
    startV = 3'b000;
    dataV  = 24'h0;
    applyStimulus(lockV, startV, dataV);
    rst_n = 1'b0;
    repeat (3) tick();

    // Reset state
    checkOutput("rst_grant", 32'(bus.grant), 0);
    checkOutput("rst_busy", 32'(bus.req_busy), 0);
    checkOutput("rst_owner", 32'(bus.owner_id), 2);
    checkOutput("rst_start", 32'(bus.uart_tx_start), 0);
    checkOutput("rst_data", 32'(bus.uart_tx_data), 0);
    checkOutput("rst_pulse", 32'(bus.timeout_pulse), 0);

    // Contention from reset release: req0 first, req1 after req0 drops
    $display("[TB] contention after reset");
    lockV = 3'b011;
    applyStimulus(lockV, startV, dataV);
    rst_n = 1'b1;
    tick();
    checkOutput("cont_grant0", 32'(bus.grant), 1);
    checkOutput("cont_owner0", 32'(bus.owner_id), 0);
    sendByte(2'd0, 8'h58);
    lockV = 3'b010;
    applyStimulus(lockV, startV, dataV);
    tick();
    checkOutput("cont_release_hold", 32'(bus.grant), 1);
    tick();
    checkOutput("cont_grant_low", 32'(bus.grant), 0);
    tick();
    checkOutput("cont_grant1", 32'(bus.grant), 2);
    checkOutput("cont_owner1", 32'(bus.owner_id), 1);
    lockV = 3'b000;
    applyStimulus(lockV, startV, dataV);
    repeat (2) tick();
    checkOutput("cont_idle", 32'(bus.grant), 0);

    // Single owner, three bytes
    $display("[TB] single owner ABC");
    logBase  = byteLog.size();
    busyBase = busyCycles;
    lockV = 3'b001;
    applyStimulus(lockV, startV, dataV);
    tick();
    checkOutput("single_grant", 32'(bus.grant), 1);
    sendByte(2'd0, 8'h41);
    checkOutput("single_grant_a", 32'(bus.grant), 1);
    sendByte(2'd0, 8'h42);
    checkOutput("single_grant_b", 32'(bus.grant), 1);
    sendByte(2'd0, 8'h43);
    checkOutput("single_grant_c", 32'(bus.grant), 1);
    checkOutput("single_count", 32'(byteLog.size() - logBase), 3);
    checkOutput("single_byte0", 32'(byteLog[logBase]), 32'h41);
    checkOutput("single_byte1", 32'(byteLog[logBase+1]), 32'h42);
    checkOutput("single_byte2", 32'(byteLog[logBase+2]), 32'h43);
    checkOutput("single_busy_cycles", 32'(busyCycles - busyBase), 30);
    lockV = 3'b000;
    applyStimulus(lockV, startV, dataV);
    repeat (2) tick();
    checkOutput("single_release", 32'(bus.grant), 0);
    checkOutput("single_owner_kept", 32'(bus.owner_id), 0);

    // Watchdog: req2 never starts, req0 pending
    $display("[TB] watchdog");
    lockV = 3'b100;
    applyStimulus(lockV, startV, dataV);
    tick();
    checkOutput("wd_grant2", 32'(bus.grant), 4);
    checkOutput("wd_owner2", 32'(bus.owner_id), 2);
    lockV = 3'b101;
    applyStimulus(lockV, startV, dataV);
    repeat (15) tick();
    checkOutput("wd_pulse_early", 32'(bus.timeout_pulse), 0);
    checkOutput("wd_grant_held", 32'(bus.grant), 4);
    tick();
    checkOutput("wd_pulse", 32'(bus.timeout_pulse), 1);
    lockV = 3'b001;
    applyStimulus(lockV, startV, dataV);
    tick();
    checkOutput("wd_pulse_end", 32'(bus.timeout_pulse), 0);
    checkOutput("wd_grant_clear", 32'(bus.grant), 0);
    tick();
    checkOutput("wd_grant0", 32'(bus.grant), 1);
    checkOutput("wd_owner0", 32'(bus.owner_id), 0);
    lockV = 3'b000;
    applyStimulus(lockV, startV, dataV);
    repeat (2) tick();
    checkOutput("wd_idle", 32'(bus.grant), 0);

    // Lock drop mid-byte with a stray start from req1
    $display("[TB] lock drop mid-byte");
    logBase = byteLog.size();
    ffBase  = ffCycles;
    lockV = 3'b001;
    applyStimulus(lockV, startV, dataV);
    tick();
    checkOutput("drop_grant0", 32'(bus.grant), 1);
    startV[0] = 1'b1;
    dataV[7:0] = 8'h41;
    applyStimulus(lockV, startV, dataV);
    waitBusy(2'd0, 1'b1, "drop_busy_rise");
    lockV = 3'b010;
    startV[1] = 1'b1;
    dataV[15:8] = 8'hFF;
    applyStimulus(lockV, startV, dataV);
    waitBusy(2'd0, 1'b0, "drop_busy_fall");
    startV = 3'b000;
    applyStimulus(lockV, startV, dataV);
    waitGrant(3'b010, "drop_grant1");
    checkOutput("drop_count", 32'(byteLog.size() - logBase), 1);
    checkOutput("drop_byte", 32'(byteLog[logBase]), 32'h41);
    checkOutput("drop_no_ff", 32'(ffCycles - ffBase), 0);
    lockV = 3'b000;
    applyStimulus(lockV, startV, dataV);
    waitGrant(3'b000, "drop_idle");

    // Reset asserted in A_TX_WAIT_DONE
    $display("[TB] reset mid-transfer");
    lockV = 3'b001;
    applyStimulus(lockV, startV, dataV);
    tick();
    startV[0] = 1'b1;
    dataV[7:0] = 8'h52;
    applyStimulus(lockV, startV, dataV);
    waitBusy(2'd0, 1'b1, "mid_busy_rise");
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("mid_start", 32'(bus.uart_tx_start), 0);
    checkOutput("mid_grant", 32'(bus.grant), 0);
    checkOutput("mid_busy", 32'(bus.req_busy), 0);
    checkOutput("mid_owner", 32'(bus.owner_id), 2);
    startV = 3'b000;
    lockV  = 3'b111;
    applyStimulus(lockV, startV, dataV);
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    checkOutput("mid_first_grant", 32'(bus.grant), 1);

    // Round-robin with all three locks held and re-raised
    $display("[TB] round robin");
    logBase = byteLog.size();
    for (int k = 0; k < 6; k++) begin
      waitGrantAny("rr_granted");
      checkOutput("rr_owner", 32'(bus.owner_id), 32'(k % 3));
      rrIdx = bus.owner_id[1:0];
      sendByte(rrIdx, 8'(8'h30 + k));
      lockV[rrIdx] = 1'b0;
      applyStimulus(lockV, startV, dataV);
      waitGrant(3'b000, "rr_release");
      lockV[rrIdx] = 1'b1;
      applyStimulus(lockV, startV, dataV);
    end
    lockV = 3'b000;
    applyStimulus(lockV, startV, dataV);
    repeat (4) tick();
    checkOutput("rr_count", 32'(byteLog.size() - logBase), 6);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
